// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store unit in front of a word-only memory: sub-word stores via read-modify-write.
// Optional statistics counters are enabled with LSU_STATS_EN.
module lsu_mem_ctrl #(
   parameter int unsigned MEM_WORDS = 256,
   parameter int unsigned STAT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_fault,
   output logic              mem_MemRW,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic [STAT_W-1:0] stat_loads,
   output logic [STAT_W-1:0] stat_stores,
   output logic [STAT_W-1:0] stat_faults
);

   localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

   typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

   state_t      state;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] merged_q;

   logic        misaligned;
   logic        illegal;
   logic        out_of_range;
   logic        req_fault;
   logic [4:0]  lane_sh;
   logic [31:0] rd_shifted;
   logic [31:0] ld_ext;
   logic [31:0] lane_mask;
   logic [31:0] merge_word;

   always_comb begin
      misaligned = 1'b0;
      case (req_funct3)
         3'b001, 3'b101: misaligned = req_addr[0];
         3'b010:         misaligned = |req_addr[1:0];
         default:        misaligned = 1'b0;
      endcase
      if (req_we)
         illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
      else
         illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
      out_of_range = ({1'b0, req_addr} >= MEM_BYTES);
      req_fault    = misaligned || illegal || out_of_range;
   end

   // Halfword accesses are aligned, so one byte-granular shift serves both widths.
   always_comb begin
      lane_sh    = {addr_q[1:0], 3'b000};
      rd_shifted = mem_rdata >> lane_sh;
      case (f3_q)
         3'b000:  ld_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
         3'b100:  ld_ext = {24'h000000, rd_shifted[7:0]};
         3'b001:  ld_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
         3'b101:  ld_ext = {16'h0000, rd_shifted[15:0]};
         default: ld_ext = mem_rdata;
      endcase
      lane_mask  = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << lane_sh;
      merge_word = (mem_rdata & ~lane_mask)
                 | (((f3_q[0] ? {16'h0000, wdata_q[15:0]} : {24'h000000, wdata_q[7:0]})
                     << lane_sh) & lane_mask);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         we_q      <= 1'b0;
         f3_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         merged_q  <= '0;
         rsp_valid <= 1'b0;
         rsp_fault <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q      <= req_we;
                  f3_q      <= req_funct3;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  req_ready <= 1'b0;
                  if (req_fault) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_fault <= 1'b1;
                     rsp_rdata <= '0;
                  end else if (!req_we) begin
                     state <= RD;
                  end else if (req_funct3 == 3'b010) begin
                     state <= WR;
                  end else begin
                     state <= RMW_RD;
                  end
               end
            end
            RD: begin
               rsp_rdata <= ld_ext;
               rsp_valid <= 1'b1;
               rsp_fault <= 1'b0;
               state     <= RESP;
            end
            RMW_RD: begin
               merged_q <= merge_word;
               state    <= WR;
            end
            WR: begin
               rsp_rdata <= '0;
               rsp_valid <= 1'b1;
               rsp_fault <= 1'b0;
               state     <= RESP;
            end
            RESP: begin
               rsp_valid <= 1'b0;
               rsp_fault <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
               rsp_fault <= 1'b0;
            end
         endcase
      end
   end

   // Decoded from state so an async reset in WR drops the write strobe at once.
   assign mem_MemRW = (state == WR);
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_wdata = (state == WR) ? ((f3_q == 3'b010) ? wdata_q : merged_q) : '0;

`ifdef LSU_STATS_EN
   logic [STAT_W-1:0] n_loads;
   logic [STAT_W-1:0] n_stores;
   logic [STAT_W-1:0] n_faults;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_loads  <= '0;
         n_stores <= '0;
         n_faults <= '0;
      end else if (state == RESP) begin
         if (rsp_fault)
            n_faults <= n_faults + STAT_W'(1);
         else if (we_q)
            n_stores <= n_stores + STAT_W'(1);
         else
            n_loads  <= n_loads + STAT_W'(1);
      end
   end

   assign stat_loads  = n_loads;
   assign stat_stores = n_stores;
   assign stat_faults = n_faults;
`else
   assign stat_loads  = '0;
   assign stat_stores = '0;
   assign stat_faults = '0;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed table-driven bench for lsu_mem_ctrl with a behavioural 256 x 32 memory.
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic        mem_MemRW;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [15:0] stat_loads;
   logic [15:0] stat_stores;
   logic [15:0] stat_faults;

   always #5 clk = ~clk;

   lsu_mem_ctrl #(.MEM_WORDS(256), .STAT_W(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
      .mem_MemRW(mem_MemRW), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_faults(stat_faults)
   );

`ifdef LSU_STATS_EN
   logic        n_rdy, n_vld, n_flt, n_rw;
   logic [31:0] n_rd, n_addr, n_wd;
   logic [1:0]  n_sl, n_ss, n_sf;
   lsu_mem_ctrl #(.MEM_WORDS(256), .STAT_W(2)) dut_w2 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(n_rdy), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(n_vld), .rsp_rdata(n_rd), .rsp_fault(n_flt),
      .mem_MemRW(n_rw), .mem_addr(n_addr), .mem_wdata(n_wd),
      .mem_rdata(mem_rdata),
      .stat_loads(n_sl), .stat_stores(n_ss), .stat_faults(n_sf)
   );
`endif

   logic [31:0] mem [256];
   logic        pre_we = 1'b0;
   logic [7:0]  pre_idx = '0;
   logic [31:0] pre_dat = '0;
   int          wr_cnt = 0;
   logic [31:0] last_waddr = '0;
   logic [31:0] last_wdata = '0;

   assign mem_rdata = mem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (pre_we) begin
         mem[pre_idx] <= pre_dat;
      end else if (mem_MemRW) begin
         mem[mem_addr[9:2]] <= mem_wdata;
         wr_cnt     <= wr_cnt + 1;
         last_waddr <= mem_addr;
         last_wdata <= mem_wdata;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic preload(input logic [7:0] idx, input logic [31:0] dat);
      @(negedge clk);
      pre_we = 1'b1; pre_idx = idx; pre_dat = dat;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // Returns at the negedge one cycle after the acceptance edge.
   task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
      chk("req_ready_at_issue", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_fault;
      int          exp_lat;
      int          exp_wr;
      logic [31:0] exp_waddr;
      logic [31:0] exp_wword;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   int lat;
   int w0;
   int exp_loads, exp_stores, exp_faults;
   int seen_valid;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b0, 3'b000, 32'h0B, 32'h0,        32'hFFFF_FFF0, 1'b0, 2, 0, 32'h0,  32'h0};
      vecs[1]  = '{1'b0, 3'b100, 32'h0B, 32'h0,        32'h0000_00F0, 1'b0, 2, 0, 32'h0,  32'h0};
      vecs[2]  = '{1'b0, 3'b001, 32'h0A, 32'h0,        32'hFFFF_F0E0, 1'b0, 2, 0, 32'h0,  32'h0};
      vecs[3]  = '{1'b0, 3'b101, 32'h08, 32'h0,        32'h0000_D0C0, 1'b0, 2, 0, 32'h0,  32'h0};
      vecs[4]  = '{1'b0, 3'b010, 32'h08, 32'h0,        32'hF0E0_D0C0, 1'b0, 2, 0, 32'h0,  32'h0};
      vecs[5]  = '{1'b1, 3'b000, 32'h11, 32'h0000_00AB, 32'h0,        1'b0, 3, 1, 32'h10, 32'h1122_AB44};
      vecs[6]  = '{1'b1, 3'b001, 32'h12, 32'h0000_BEEF, 32'h0,        1'b0, 3, 1, 32'h10, 32'hBEEF_AB44};
      vecs[7]  = '{1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'h0,        1'b0, 2, 1, 32'h20, 32'hDEAD_BEEF};
      vecs[8]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'hBEEF_AB44, 1'b0, 2, 0, 32'h0,  32'h0};
      vecs[9]  = '{1'b0, 3'b010, 32'h20, 32'h0,        32'hDEAD_BEEF, 1'b0, 2, 0, 32'h0,  32'h0};
      vecs[10] = '{1'b0, 3'b010, 32'h3FC, 32'h0,       32'hCAFE_F00D, 1'b0, 2, 0, 32'h0,  32'h0};
      vecs[11] = '{1'b0, 3'b010, 32'h06, 32'h0,        32'h0,         1'b1, 1, 0, 32'h0,  32'h0};
      vecs[12] = '{1'b1, 3'b001, 32'h03, 32'h1234,     32'h0,         1'b1, 1, 0, 32'h0,  32'h0};
      vecs[13] = '{1'b0, 3'b010, 32'h400, 32'h0,       32'h0,         1'b1, 1, 0, 32'h0,  32'h0};
      vecs[14] = '{1'b0, 3'b011, 32'h00, 32'h0,        32'h0,         1'b1, 1, 0, 32'h0,  32'h0};
      vecs[15] = '{1'b1, 3'b100, 32'h00, 32'h55,       32'h0,         1'b1, 1, 0, 32'h0,  32'h0};
      vecs[16] = '{1'b0, 3'b000, 32'h3FF, 32'h0,       32'hFFFF_FFCA, 1'b0, 2, 0, 32'h0,  32'h0};

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_mem_MemRW", 32'(mem_MemRW), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_stat_loads", 32'(stat_loads), 32'd0);

      preload(8'd2, 32'hF0E0_D0C0);
      preload(8'd4, 32'h1122_3344);
      preload(8'd8, 32'h0);
      preload(8'd255, 32'hCAFE_F00D);

      // Reset asserted mid-cycle while in WR of sb 0x11: strobe must drop before the next edge.
      w0 = wr_cnt;
      send(1'b1, 3'b000, 32'h11, 32'hAB);
      @(negedge clk);
      chk("rstwr_in_wr", 32'(mem_MemRW), 32'd1);
      chk("rstwr_wdata", mem_wdata, 32'h1122_AB44);
      rst = 1'b1;
      #1;
      chk("rstwr_memrw_drop", 32'(mem_MemRW), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rstwr_word_kept", mem[4], 32'h1122_3344);
      chk("rstwr_no_write", 32'(wr_cnt - w0), 32'd0);
      chk("rstwr_req_ready", 32'(req_ready), 32'd1);

      // Reset while in RD: the load must never respond.
      seen_valid = 0;
      send(1'b0, 3'b010, 32'h08, 32'h0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (rsp_valid) seen_valid++;
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (rsp_valid) seen_valid++;
      end
      chk("rstrd_no_rsp_valid", 32'(seen_valid), 32'd0);
      chk("rstrd_req_ready", 32'(req_ready), 32'd1);
      chk("rstrd_rsp_rdata", rsp_rdata, 32'd0);

      exp_loads = 0; exp_stores = 0; exp_faults = 0;
      for (int i = 0; i < NV; i++) begin
         w0 = wr_cnt;
         send(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
         wait_rsp(lat);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
         chk($sformatf("v%0d_rsp_fault", i), 32'(rsp_fault), 32'(vecs[i].exp_fault));
         chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].exp_rdata);
         chk($sformatf("v%0d_write_cycles", i), 32'(wr_cnt - w0), 32'(vecs[i].exp_wr));
         if (vecs[i].exp_wr > 0) begin
            chk($sformatf("v%0d_write_addr", i), last_waddr, vecs[i].exp_waddr);
            chk($sformatf("v%0d_write_word", i), last_wdata, vecs[i].exp_wword);
         end
         @(negedge clk);
         chk($sformatf("v%0d_pulse_end", i), 32'(rsp_valid), 32'd0);
         chk($sformatf("v%0d_ready_again", i), 32'(req_ready), 32'd1);
         chk($sformatf("v%0d_rdata_hold", i), rsp_rdata, vecs[i].exp_rdata);
         if (vecs[i].exp_fault) exp_faults++;
         else if (vecs[i].we)   exp_stores++;
         else                   exp_loads++;
      end

`ifdef LSU_STATS_EN
      chk("stat_loads", 32'(stat_loads), 32'(exp_loads));
      chk("stat_stores", 32'(stat_stores), 32'(exp_stores));
      chk("stat_faults", 32'(stat_faults), 32'(exp_faults));
      chk("stat_w2_loads_wrap", 32'(n_sl), 32'(exp_loads % 4));
      chk("stat_w2_stores", 32'(n_ss), 32'(exp_stores % 4));
      chk("stat_w2_faults", 32'(n_sf), 32'(exp_faults % 4));
`else
      chk("stat_loads_tied", 32'(stat_loads), 32'd0);
      chk("stat_stores_tied", 32'(stat_stores), 32'd0);
      chk("stat_faults_tied", 32'(stat_faults), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator between the RV32I execute stage and the word-only data memory (MemRW / addr / write_data / read_data, async read, sync write, 256 x 32).
- Converts byte, halfword and word loads and stores into word accesses.
- Sub-word stores use a read-modify-write sequence, because the memory has no byte enables.
- Performs sign/zero extension on loads and detects misaligned and out-of-range accesses.

Parameters:
MEM_WORDS, 256, number of 32-bit words behind the memory; byte addresses >= MEM_WORDS*4 fault.
STAT_W, 16, width of statistics counters (used only with LSU_STATS_EN).

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready at posedge
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  byte address
req_wdata  in  32  store data; low bits used for B/H
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load data; 0 for stores and faults
rsp_fault  out  1  valid with rsp_valid: misaligned, out-of-range or illegal funct3
mem_MemRW  out  1  to memory: 1 = write
mem_addr  out  32  to memory: word-aligned byte address, bits [1:0] = 0
mem_wdata  out  32  to memory write data
mem_rdata  in  32  from memory, combinational read
stat_loads  out  STAT_W  completed loads
stat_stores  out  STAT_W  completed stores
stat_faults  out  STAT_W  faulted requests

Behaviour:
- States: IDLE, RD, RMW_RD, WR, RESP.
- Acceptance latches we, funct3, addr and wdata into registers.
- Fault check at acceptance:
  - misaligned: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0.
  - out of range: addr >= MEM_WORDS*4.
  - illegal funct3: loads 011/110/111; stores other than 000/001/010.
- Transitions out of IDLE on acceptance:
  - Fault -> RESP. No memory access occurs.
  - Load -> RD.
  - SW -> WR.
  - SB/SH -> RMW_RD.
- RD: mem_addr = {addr_q[31:2],2'b00}, mem_MemRW=0. Select the byte/half by addr_q[1:0], extend it, register it into rsp_rdata -> RESP.
- RMW_RD: read the word and merge it into a register:
  - SB: replaces byte lane addr_q[1:0] with wdata_q[7:0].
  - SH: replaces half lane addr_q[1] with wdata_q[15:0].
  - -> WR.
- WR: mem_MemRW=1 for exactly this one cycle; mem_wdata = merged word (SB/SH) or wdata_q (SW) -> RESP.
- RESP: rsp_valid=1 and rsp_fault set for one cycle -> IDLE. req_ready stays 0 in RESP, so back-to-back requests are spaced.
- Latency, counted from acceptance edge to rsp_valid cycle:
  - fault: 1 cycle
  - load: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
- mem_MemRW is decoded combinationally from state and is 1 only in WR.
- mem_addr is driven from addr_q in all states. mem_wdata is 0 outside WR.
- rsp_rdata holds its value until the next load response. Stores and faults drive it to 0.
- Reset, async at any time:
  - state -> IDLE.
  - All registers and outputs -> 0, except req_ready, which is 1.
  - A reset asserted during WR drops mem_MemRW immediately, so no write completes at the next edge.
  - A reset during RMW_RD leaves memory unmodified.
- req_valid while busy is ignored. The requester must hold it until req_ready.

Optional Feature:
- LSU_STATS_EN defined:
  - stat_loads, stat_stores and stat_faults each increment by 1 in the RESP cycle of the matching request.
  - Counters wrap at 2^STAT_W and clear on rst.
  - A faulted request increments stat_faults only.
- LSU_STATS_EN undefined: the three ports are tied to 0 and no counter logic is present.

Test Plan:
- Memory word @0x8 = 0xF0E0D0C0:
  - lb 0xB -> rsp_rdata 0xFFFFFFF0
  - lbu 0xB -> 0x000000F0
  - lh 0xA -> 0xFFFFF0E0
  - lhu 0x8 -> 0x0000D0C0
  - lw 0x8 -> 0xF0E0D0C0
  - each with rsp_valid 2 cycles after acceptance and mem_MemRW=0 throughout.
- Word @0x10 = 0x11223344:
  - sb 0x11 with wdata 0x000000AB -> exactly one write cycle of 0x1122AB44, rsp_valid 3 cycles after acceptance.
  - then sh 0x12 with wdata 0xBEEF -> 0xBEEFAB44.
- sw 0x20 with wdata 0xDEADBEEF -> one write of 0xDEADBEEF at mem_addr 0x20, rsp_valid after 2 cycles, rsp_rdata 0.
- Faults, each giving rsp_fault=1 after 1 cycle and mem_MemRW never high:
  - lw 0x6
  - sh 0x3
  - lw 0x400 (MEM_WORDS=256)
  - load funct3 011
- Assert rst mid-operation:
  - during WR of sb 0x11: mem_MemRW falls the same cycle, word stays 0x11223344, req_ready=1 after release.
  - during RD: no rsp_valid.
- With LSU_STATS_EN: 3 loads, 2 stores, 1 fault -> stat_loads 3, stat_stores 2, stat_faults 1. STAT_W=2 with 5 loads -> stat_loads 1 (wrap).
